rect_drawer: RTL and testbench

- Parametrised rectangle rasteriser: given two corner points, a colour and a mode, it emits one pixel coordinate per accepted cycle in raster order.
- Modes: solid fill, or 1-pixel outline.
- Runs on the system clock and uses a valid/ready pixel handshake, so no divided clock is needed.
- Sits between the draw/object control logic and the pixel-write path (line/framebuffer writer).

---
 rtl/rect_drawer.sv | 136 +++++++++++++
 tb/tb_rect_drawer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rect_drawer.sv
// Rectangle rasteriser: normalises two corners and streams one pixel per accepted
// cycle in raster order, either solid fill or a 1-pixel outline.
module rect_drawer #(
  parameter int XW = 11,
  parameter int YW = 11,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] color_in,
  input  logic          mode,
  input  logic          ready,
  output logic          busy,
  output logic          done,
  output logic          pix_valid,
  output logic [XW-1:0] xDraw,
  output logic [YW-1:0] yDraw,
  output logic [CW-1:0] color_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [XW-1:0] xmin_r, xmax_r, x_r, xmin_s, xmax_s, x_s;
  logic [YW-1:0] ymin_r, ymax_r, y_r, ymin_s, ymax_s, y_s;
  logic [CW-1:0] color_r, color_s;
  logic          mode_r, mode_s;
  logic          busy_r, done_r, valid_r;
  logic          row_end_s, rect_end_s, interior_s;

  // End detection compares before incrementing, so all-ones corners never wrap.
  assign row_end_s  = (x_r == xmax_r);
  assign rect_end_s = row_end_s && (y_r == ymax_r);
  assign interior_s = mode_r && (y_r != ymin_r) && (y_r != ymax_r);

  // Next-state and next-pixel computation.
  always_comb begin
    state_s = state_r;
    xmin_s  = xmin_r;
    xmax_s  = xmax_r;
    ymin_s  = ymin_r;
    ymax_s  = ymax_r;
    x_s     = x_r;
    y_s     = y_r;
    color_s = color_r;
    mode_s  = mode_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          xmin_s  = (x0 <= x1) ? x0 : x1;
          xmax_s  = (x0 <= x1) ? x1 : x0;
          ymin_s  = (y0 <= y1) ? y0 : y1;
          ymax_s  = (y0 <= y1) ? y1 : y0;
          x_s     = xmin_s;
          y_s     = ymin_s;
          color_s = color_in;
          mode_s  = mode;
          state_s = DRAW;
        end else begin
          state_s = IDLE;
        end
      end
      DRAW: begin
        // pix_valid is always high in DRAW, so ready alone means accepted.
        if (ready) begin
          if (rect_end_s) begin
            state_s = DONE;
          end else if (row_end_s) begin
            x_s = xmin_r;
            y_s = y_r + YW'(1);
          end else if (interior_s) begin
            x_s = xmax_r;
          end else begin
            x_s = x_r + XW'(1);
          end
        end else begin
          state_s = DRAW;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      xmin_r  <= '0;
      xmax_r  <= '0;
      ymin_r  <= '0;
      ymax_r  <= '0;
      x_r     <= '0;
      y_r     <= '0;
      color_r <= '0;
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      xmin_r  <= xmin_s;
      xmax_r  <= xmax_s;
      ymin_r  <= ymin_s;
      ymax_r  <= ymax_s;
      x_r     <= x_s;
      y_r     <= y_s;
      color_r <= color_s;
      mode_r  <= mode_s;
      busy_r  <= (state_s == DRAW);
      done_r  <= (state_s == DONE);
      valid_r <= (state_s == DRAW);
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign pix_valid = valid_r;
  assign xDraw     = x_r;
  assign yDraw     = y_r;
  assign color_out = color_r;

endmodule

// File: tb/tb_rect_drawer.sv
// Directed self-checking bench for rect_drawer: inputs driven and outputs
// checked on the falling edge, expected pixels written out by hand.
module tb_rect_drawer;

  localparam int XW = 11;
  localparam int YW = 11;
  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic          start;
  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic [CW-1:0] color_in;
  logic          mode;
  logic          ready;
  logic          busy, done, pix_valid;
  logic [XW-1:0] xDraw;
  logic [YW-1:0] yDraw;
  logic [CW-1:0] color_out;

  int checks   = 0;
  int failures = 0;
  int npix     = 0;

  rect_drawer #(.XW(XW), .YW(YW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .color_in(color_in), .mode(mode), .ready(ready),
    .busy(busy), .done(done), .pix_valid(pix_valid),
    .xDraw(xDraw), .yDraw(yDraw), .color_out(color_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_rect(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int c, input logic m);
    x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1);
    color_in = CW'(c); mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color_in = '0; mode = ~m;
  endtask

  // Check the currently presented pixel, drive ready for the coming edge, advance.
  task automatic pix(input string tag, input int ex, input int ey, input int ec, input logic r);
    ready = r;
    check({tag, ".valid"}, 32'(pix_valid), 32'd1);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".x"}, 32'(xDraw), 32'(ex));
    check({tag, ".y"}, 32'(yDraw), 32'(ey));
    check({tag, ".color"}, 32'(color_out), 32'(ec));
    if (r) npix++;
    @(negedge clk);
  endtask

  // Done pulse after the last pixel, then back to idle one cycle later.
  task automatic finish_rect(input string tag, input int ex, input int ey, input int ec,
                             input int epix);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check({tag, ".valid_done"}, 32'(pix_valid), 32'd0);
    check({tag, ".x_hold"}, 32'(xDraw), 32'(ex));
    check({tag, ".y_hold"}, 32'(yDraw), 32'(ey));
    check({tag, ".c_hold"}, 32'(color_out), 32'(ec));
    check({tag, ".npix"}, 32'(npix), 32'(epix));
    npix = 0;
    @(negedge clk);
    check({tag, ".done_low"}, 32'(done), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check({tag, ".idle_valid"}, 32'(pix_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ready = 1'b1; mode = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color_in = '0;
    @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.valid", 32'(pix_valid), 32'd0);
    check("rst.x", 32'(xDraw), 32'd0);
    check("rst.y", 32'(yDraw), 32'd0);
    check("rst.c", 32'(color_out), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Fill 3x2.
    start_rect(2, 3, 4, 4, 5, 1'b0);
    pix("f1", 2, 3, 5, 1'b1); pix("f1", 3, 3, 5, 1'b1); pix("f1", 4, 3, 5, 1'b1);
    pix("f1", 2, 4, 5, 1'b1); pix("f1", 3, 4, 5, 1'b1); pix("f1", 4, 4, 5, 1'b1);
    finish_rect("f1", 4, 4, 5, 6);

    // Outline with swapped corners, normalised to (1,1)-(5,5).
    start_rect(5, 5, 1, 1, 7, 1'b1);
    for (int x = 1; x <= 5; x++) pix("o_top", x, 1, 7, 1'b1);
    for (int y = 2; y <= 4; y++) begin
      pix("o_mid_l", 1, y, 7, 1'b1);
      pix("o_mid_r", 5, y, 7, 1'b1);
    end
    for (int x = 1; x <= 5; x++) pix("o_bot", x, 5, 7, 1'b1);
    finish_rect("o", 5, 5, 7, 16);

    // Backpressure, ready 1,0,0,1,1,0,1.
    start_rect(0, 0, 1, 1, 2, 1'b0);
    pix("bp0", 0, 0, 2, 1'b1);
    pix("bp1", 1, 0, 2, 1'b0);
    pix("bp2", 1, 0, 2, 1'b0);
    pix("bp3", 1, 0, 2, 1'b1);
    pix("bp4", 0, 1, 2, 1'b1);
    pix("bp5", 1, 1, 2, 1'b0);
    pix("bp6", 1, 1, 2, 1'b1);
    finish_rect("bp", 1, 1, 2, 4);

    // Single point at the all-ones corner.
    start_rect(2047, 2047, 2047, 2047, 6, 1'b0);
    pix("pt", 2047, 2047, 6, 1'b1);
    finish_rect("pt", 2047, 2047, 6, 1);

    // Vertical line in outline mode.
    start_rect(7, 0, 7, 3, 1, 1'b1);
    for (int y = 0; y <= 3; y++) pix("vl", 7, y, 1, 1'b1);
    finish_rect("vl", 7, 3, 1, 4);

    // Start while busy is ignored.
    start_rect(0, 0, 2, 0, 4, 1'b0);
    pix("sb0", 0, 0, 4, 1'b1);
    x0 = 11'd9; y0 = 11'd9; x1 = 11'd12; y1 = 11'd12; color_in = 3'd1; start = 1'b1;
    pix("sb1", 1, 0, 4, 1'b1);
    pix("sb2", 2, 0, 4, 1'b1);
    start = 1'b0;
    finish_rect("sb", 2, 0, 4, 3);
    // Back-to-back start as soon as idle.
    start_rect(3, 1, 3, 1, 3, 1'b0);
    pix("bb", 3, 1, 3, 1'b1);
    finish_rect("bb", 3, 1, 3, 1);

    // Reset during the third pixel of a 3x3 fill.
    start_rect(0, 0, 2, 2, 5, 1'b0);
    pix("rm0", 0, 0, 5, 1'b1);
    pix("rm1", 1, 0, 5, 1'b1);
    check("rm2.x", 32'(xDraw), 32'd2);
    reset = 1'b0;
    #1;
    check("rm.busy", 32'(busy), 32'd0);
    check("rm.valid", 32'(pix_valid), 32'd0);
    check("rm.x", 32'(xDraw), 32'd0);
    check("rm.c", 32'(color_out), 32'd0);
    @(negedge clk);
    check("rm.done", 32'(done), 32'd0);
    reset = 1'b1;
    npix = 0;
    @(negedge clk);
    check("rm.after_done", 32'(done), 32'd0);
    check("rm.after_valid", 32'(pix_valid), 32'd0);
    start_rect(0, 0, 0, 0, 2, 1'b0);
    pix("rp", 0, 0, 2, 1'b1);
    finish_rect("rp", 0, 0, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
